// File: rtl/ids_drop_gate_pkg.sv
// Shared widths, defaults and FSM state encoding for the IDS drop gate.
package ids_drop_gate_pkg;

  localparam int IDS_DATA_WIDTH      = 64;
  localparam int IDS_CTRL_WIDTH      = IDS_DATA_WIDTH / 8;
  localparam int IDS_DROP_DEPTH_BITS = 8;
  localparam int IDS_MATCH_LAT       = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_DECIDE  = 3'd3,
    ST_DISCARD = 3'd4
  } gate_state_e;

endpackage

// File: rtl/ids_drop_gate_if.sv
// Packet word stream (data + ctrl) with write strobe and ready; master drives the word.
interface ids_drop_gate_if
  import ids_drop_gate_pkg::*;
#(
  parameter int DATA_WIDTH = IDS_DATA_WIDTH,
  parameter int CTRL_WIDTH = IDS_CTRL_WIDTH
) ();

  logic [DATA_WIDTH-1:0] data;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic                  wr;
  logic                  rdy;

  modport master (output data, output ctrl, output wr, input rdy);
  modport slave  (input data, input ctrl, input wr, output rdy);

endinterface

// File: rtl/ids_drop_gate_ram.sv
// Simple dual-port packet RAM: one write port, one read port, read data registered (1 cycle).
module ids_pkt_ram #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 72
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdat_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdat_o
);

  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic [WORD_W-1:0] rdat_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdat_i;
  end

  // Output register is reset so egress data reads as zero straight out of reset.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)  rdat_q <= '0;
    else if (re_i) rdat_q <= mem[raddr_i];
  end

  assign rdat_o = rdat_q;

endmodule

// File: rtl/ids_drop_gate.sv
// Store-and-forward gate: buffers each packet, then commits or discards it at EOP on the match flag.
// First word out MATCH_LAT+2 cycles after EOP; ingress stalls only when full of committed data.
module ids_drop_gate
  import ids_drop_gate_pkg::*;
#(
  parameter int DATA_WIDTH = IDS_DATA_WIDTH,
  parameter int CTRL_WIDTH = IDS_CTRL_WIDTH,
  parameter int DEPTH_BITS = IDS_DROP_DEPTH_BITS,
  parameter int MATCH_LAT  = IDS_MATCH_LAT
) (
  input  logic                  clk,
  input  logic                  reset_L,
  ids_drop_gate_if.slave        in_if,
  input  logic                  in_match,
  input  logic                  drop_en,
  ids_drop_gate_if.master       out_if,
  output logic [31:0]           pass_cnt,
  output logic [31:0]           drop_cnt,
  output logic [31:0]           ovf_cnt
);

  localparam int PW = DEPTH_BITS + 1;
  localparam int WW = CTRL_WIDTH + DATA_WIDTH;
  localparam int LW = (MATCH_LAT > 1) ? $clog2(MATCH_LAT) : 1;

  gate_state_e   state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q;
  logic          match_seen_q, match_seen_d;
  logic          disc_pl_q, disc_pl_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          live_q;
  logic          out_wr_q;
  logic [31:0]   pass_q, drop_q, ovf_q;

  logic          full, pkt_fills, in_rdy, accept, is_marker, match_now;
  logic          ram_we, rd_en;
  logic          pass_inc, drop_inc, ovf_inc;
  logic [WW-1:0] rd_word;

  assign full      = (wr_ptr_q - rd_ptr_q) == PW'(1 << DEPTH_BITS);
  assign pkt_fills = full & (rd_ptr_q == commit_ptr_q);
  assign is_marker = |in_if.ctrl;
  assign match_now = match_seen_q | in_match;
  assign accept    = in_if.wr & in_rdy;
  assign rd_en     = (rd_ptr_q != commit_ptr_q) & out_if.rdy;

  // When the current packet alone fills the buffer, stalling would deadlock, so keep
  // accepting and let the FSM swallow the rest of the packet.
  always_comb begin
    in_rdy = 1'b0;
    if (live_q) begin
      case (state_q)
        ST_DISCARD:         in_rdy = 1'b1;
        ST_DECIDE:          in_rdy = 1'b0;
        ST_HDR, ST_PAYLOAD: in_rdy = !full | pkt_fills;
        default:            in_rdy = !full;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    match_seen_d = match_seen_q;
    disc_pl_d    = disc_pl_q;
    lat_d        = lat_q;
    ram_we       = 1'b0;
    pass_inc     = 1'b0;
    drop_inc     = 1'b0;
    ovf_inc      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        match_seen_d = 1'b0;
        if (accept) begin
          ram_we       = 1'b1;
          wr_ptr_d     = wr_ptr_q + PW'(1);
          match_seen_d = in_match;
          state_d      = ST_HDR;
        end
      end
      ST_HDR: begin
        match_seen_d = match_now;
        if (accept) begin
          if (full) begin
            disc_pl_d = !is_marker;
            state_d   = ST_DISCARD;
          end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (!is_marker) state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        match_seen_d = match_now;
        if (accept) begin
          if (full && is_marker) begin
            wr_ptr_d = commit_ptr_q;
            ovf_inc  = 1'b1;
            state_d  = ST_IDLE;
          end else if (full) begin
            disc_pl_d = 1'b1;
            state_d   = ST_DISCARD;
          end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (is_marker) begin
              lat_d   = '0;
              state_d = ST_DECIDE;
            end
          end
        end
      end
      ST_DECIDE: begin
        match_seen_d = match_now;
        if (lat_q == LW'(MATCH_LAT - 1)) begin
          if (match_now && drop_en) begin
            wr_ptr_d = commit_ptr_q;
            drop_inc = 1'b1;
          end else begin
            commit_ptr_d = wr_ptr_q;
            pass_inc     = 1'b1;
          end
          state_d = ST_IDLE;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      ST_DISCARD: begin
        // A marker only ends the packet once payload has been seen; earlier markers are headers.
        if (accept) begin
          if (is_marker && disc_pl_q) begin
            wr_ptr_d = commit_ptr_q;
            ovf_inc  = 1'b1;
            state_d  = ST_IDLE;
          end else if (!is_marker) begin
            disc_pl_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      match_seen_q <= 1'b0;
      disc_pl_q    <= 1'b0;
      lat_q        <= '0;
      live_q       <= 1'b0;
      out_wr_q     <= 1'b0;
      pass_q       <= '0;
      drop_q       <= '0;
      ovf_q        <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      match_seen_q <= match_seen_d;
      disc_pl_q    <= disc_pl_d;
      lat_q        <= lat_d;
      live_q       <= 1'b1;
      out_wr_q     <= rd_en;
      if (rd_en)    rd_ptr_q <= rd_ptr_q + PW'(1);
      if (pass_inc) pass_q   <= pass_q + 32'd1;
      if (drop_inc) drop_q   <= drop_q + 32'd1;
      if (ovf_inc)  ovf_q    <= ovf_q + 32'd1;
    end
  end

  ids_pkt_ram #(
    .ADDR_W (DEPTH_BITS),
    .WORD_W (WW)
  ) u_ram (
    .clk     (clk),
    .reset_L (reset_L),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[DEPTH_BITS-1:0]),
    .wdat_i  ({in_if.ctrl, in_if.data}),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q[DEPTH_BITS-1:0]),
    .rdat_o  (rd_word)
  );

  assign in_if.rdy   = in_rdy;
  assign out_if.data = rd_word[DATA_WIDTH-1:0];
  assign out_if.ctrl = rd_word[WW-1:DATA_WIDTH];
  assign out_if.wr   = out_wr_q;
  assign pass_cnt    = pass_q;
  assign drop_cnt    = drop_q;
  assign ovf_cnt     = ovf_q;

endmodule

// File: tb/tb_ids_drop_gate.sv
// Directed bench for ids_drop_gate (16-word buffer, MATCH_LAT=1): packet table plus backpressure/reset sequences.
module tb_ids_drop_gate;
  import ids_drop_gate_pkg::*;

  logic        clk = 1'b0;
  logic        reset_L;
  logic        in_match;
  logic        drop_en;
  logic [31:0] pass_cnt, drop_cnt, ovf_cnt;

  ids_drop_gate_if in_if ();
  ids_drop_gate_if out_if ();

  ids_drop_gate #(
    .DATA_WIDTH (64),
    .CTRL_WIDTH (8),
    .DEPTH_BITS (4),
    .MATCH_LAT  (1)
  ) dut (
    .clk      (clk),
    .reset_L  (reset_L),
    .in_if    (in_if),
    .in_match (in_match),
    .drop_en  (drop_en),
    .out_if   (out_if),
    .pass_cnt (pass_cnt),
    .drop_cnt (drop_cnt),
    .ovf_cnt  (ovf_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int acc   = 0;
  int eop_cyc = 0;
  logic [71:0] got_q[$];
  int          got_cyc[$];
  logic [71:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_if.wr) begin
      got_q.push_back({out_if.ctrl, out_if.data});
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int len;
    int nhdr;
    int midx;
    bit den;
    int exp_words;
    int exp_pass;
    int exp_drop;
    int exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] mk_word(input logic [7:0] tag, input int i, input int nhdr, input int len);
    logic [7:0] c;
    if (i < nhdr)          c = 8'hFF;
    else if (i == len - 1) c = 8'h01;
    else                   c = 8'h00;
    return {c, tag, 8'(i), 16'hC0DE, 32'(i) * 32'h0101_0101};
  endfunction

  task automatic send_pkt(input int len, input int nhdr, input int midx, input logic [7:0] tag,
                          input bit keep, output int stalls);
    logic [71:0] w;
    bit r;
    bit done;
    int c;
    stalls = 0;
    for (int i = 0; i < len; i++) begin
      w = mk_word(tag, i, nhdr, len);
      in_if.ctrl = w[71:64];
      in_if.data = w[63:0];
      in_if.wr   = 1'b1;
      in_match   = (i == midx);
      done = 1'b0;
      while (!done) begin
        @(negedge clk);
        r = in_if.rdy;
        c = cyc;
        @(posedge clk);
        #1;
        if (r) begin
          done = 1'b1;
        end else begin
          stalls++;
          if (stalls > 400) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: tag %0h word %0d never accepted", tag, i);
            in_if.wr = 1'b0;
            in_match = 1'b0;
            return;
          end
        end
      end
      acc++;
      if (keep) exp_q.push_back(w);
      if (i == len - 1) eop_cyc = c;
    end
    in_if.wr = 1'b0;
    in_match = (midx == len);
    @(posedge clk);
    #1;
    in_match = 1'b0;
  endtask

  task automatic chk_stream(input string name);
    chk({name, "_count"}, 72'(got_q.size()), 72'(exp_q.size()));
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++)
      chk({name, "_word"}, got_q[j], exp_q[j]);
  endtask

  vec_t vecs[9];

  initial begin
    int stalls;
    int base_pass;

    vecs[0] = '{6,  1, -1, 1'b1, 6, 1, 0, 0};
    vecs[1] = '{6,  1,  2, 1'b1, 0, 1, 1, 0};
    vecs[2] = '{6,  1, -1, 1'b1, 6, 2, 1, 0};
    vecs[3] = '{6,  1,  6, 1'b1, 0, 2, 2, 0};
    vecs[4] = '{6,  1,  6, 1'b0, 6, 3, 2, 0};
    vecs[5] = '{20, 1, -1, 1'b1, 0, 3, 2, 1};
    vecs[6] = '{6,  1, -1, 1'b1, 6, 4, 2, 1};
    vecs[7] = '{6,  2,  0, 1'b1, 0, 4, 3, 1};
    vecs[8] = '{6,  2, -1, 1'b1, 6, 5, 3, 1};

    reset_L     = 1'b0;
    in_if.wr    = 1'b0;
    in_if.data  = '0;
    in_if.ctrl  = '0;
    in_match    = 1'b0;
    drop_en     = 1'b1;
    out_if.rdy  = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_rdy", 72'(in_if.rdy), 72'(0));
    chk("rst_out_wr", 72'(out_if.wr), 72'(0));
    chk("rst_out_word", {out_if.ctrl, out_if.data}, 72'(0));
    chk("rst_pass", 72'(pass_cnt), 72'(0));
    chk("rst_drop", 72'(drop_cnt), 72'(0));
    chk("rst_ovf", 72'(ovf_cnt), 72'(0));
    @(negedge clk);
    reset_L = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy_after_release", 72'(in_if.rdy), 72'(1));

    for (int v = 0; v < 9; v++) begin
      drop_en = vecs[v].den;
      got_q.delete();
      got_cyc.delete();
      exp_q.delete();
      send_pkt(vecs[v].len, vecs[v].nhdr, vecs[v].midx, 8'(8'h10 + v), vecs[v].exp_words != 0, stalls);
      repeat (30) @(posedge clk);
      #1;
      chk($sformatf("v%0d_stalls", v), 72'(stalls), 72'(0));
      chk($sformatf("v%0d_pass", v), 72'(pass_cnt), 72'(vecs[v].exp_pass));
      chk($sformatf("v%0d_drop", v), 72'(drop_cnt), 72'(vecs[v].exp_drop));
      chk($sformatf("v%0d_ovf", v), 72'(ovf_cnt), 72'(vecs[v].exp_ovf));
      chk($sformatf("v%0d_words", v), 72'(got_q.size()), 72'(vecs[v].exp_words));
      chk_stream($sformatf("v%0d", v));
      if (got_cyc.size() > 0)
        chk($sformatf("v%0d_latency", v), 72'(got_cyc[0] - eop_cyc), 72'(3));
    end

    // Egress blocked while three packets arrive: 16 words fit, then ingress stalls.
    drop_en   = 1'b1;
    out_if.rdy = 1'b0;
    got_q.delete();
    exp_q.delete();
    acc = 0;
    base_pass = int'(pass_cnt);
    fork
      begin
        send_pkt(6, 1, -1, 8'h51, 1'b1, stalls);
        send_pkt(6, 1, -1, 8'h52, 1'b1, stalls);
        send_pkt(6, 1, -1, 8'h53, 1'b1, stalls);
      end
      begin
        repeat (60) @(posedge clk);
        #2;
        chk("bp_accepted", 72'(acc), 72'(16));
        chk("bp_in_rdy", 72'(in_if.rdy), 72'(0));
        chk("bp_no_out", 72'(got_q.size()), 72'(0));
        out_if.rdy = 1'b1;
      end
    join
    repeat (40) @(posedge clk);
    #1;
    chk_stream("bp");
    chk("bp_pass", 72'(pass_cnt), 72'(base_pass + 3));

    // Reset while one packet is egressing and the next is mid-payload.
    out_if.rdy = 1'b0;
    send_pkt(6, 1, -1, 8'h61, 1'b0, stalls);
    for (int i = 0; i < 3; i++) begin
      {in_if.ctrl, in_if.data} = mk_word(8'h62, i, 1, 6);
      in_if.wr = 1'b1;
      @(posedge clk);
      #1;
    end
    in_if.wr = 1'b0;
    out_if.rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_egress", 72'(out_if.wr), 72'(1));
    #2;
    reset_L = 1'b0;
    #1;
    chk("mid_rst_out_wr", 72'(out_if.wr), 72'(0));
    chk("mid_rst_out_word", {out_if.ctrl, out_if.data}, 72'(0));
    chk("mid_rst_in_rdy", 72'(in_if.rdy), 72'(0));
    chk("mid_rst_pass", 72'(pass_cnt), 72'(0));
    chk("mid_rst_drop", 72'(drop_cnt), 72'(0));
    chk("mid_rst_ovf", 72'(ovf_cnt), 72'(0));
    @(negedge clk);
    reset_L = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_rdy", 72'(in_if.rdy), 72'(1));
    got_q.delete();
    exp_q.delete();
    send_pkt(6, 1, -1, 8'h63, 1'b1, stalls);
    repeat (30) @(posedge clk);
    #1;
    chk_stream("post_rst");
    chk("post_rst_pass", 72'(pass_cnt), 72'(1));
    chk("post_rst_drop", 72'(drop_cnt), 72'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
